mult_div_unit: RTL and testbench

- Iterative multiply/divide unit that produces the {HI, LO} result pair and writes it into the HI/LO register block. It is the producer end of that register interface.
- Sits in the EX stage beside the ALU. It accepts one operation per start pulse and asserts busy while computing, so the pipeline stalls on mfhi/mflo hazards.
- It emits one hilo_write pulse with hi_out/lo_out valid in the same cycle.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_datapath.sv | 62 ++++++
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the divide-by-zero quotient constant.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  // Wide enough for any supported DATA_W; users slice off what they need.
  localparam logic [63:0] DIV0_LO = {64{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SIGN  = 2'd2,
    S_WRITE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Iterative core of the multiply/divide unit: one unsigned shift-add or
// restoring shift-subtract step per cycle on a 2*DATA_W accumulator.
module mdu_datapath #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  div_i,
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  output logic [2*DATA_W-1:0]   acc_o,
  output logic                  last_o
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q;
  logic                div_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W+1:0]   div_diff;

  // Multiply keeps the multiplier in the low half and adds the multiplicand
  // into the high half; divide shifts the dividend up into the remainder.
  always_comb begin
    acc_d    = acc_q;
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_diff = {1'b0, acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {2'b00, opnd_q};
    if (div_q) begin
      if (!div_diff[DATA_W+1])
        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      else
        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= {{DATA_W{1'b0}}, (div_i ? opa_i : opb_i)};
      opnd_q <= div_i ? opb_i : opa_i;
      div_q  <= div_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the HI/LO register block.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic              busy,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hilo_write
);

  mdu_state_e state_q, state_d;

  logic [2:0]          op_q;
  logic                sign_a_q, sign_b_q, b_zero_q;
  logic [DATA_W-1:0]   src_a_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [2*DATA_W-1:0] acc;
  logic                last;

  logic                op_legal, accept, in_signed, in_div, sign_a, sign_b;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                q_signed, q_div;
  logic [2*DATA_W-1:0] prod, result;
  logic [DATA_W-1:0]   quot, rem;

`ifdef MDU_MADD_EN
  logic [DATA_W-1:0]   hi_in_q, lo_in_q;
  assign op_legal = 1'b1;
`else
  logic                unused_hilo_in;
  assign unused_hilo_in = ^{hi_in, lo_in};
  assign op_legal = ~op[2];
`endif

  assign in_signed = ~op[0];
  assign in_div    = (op[2:1] == 2'b01);
  assign sign_a    = in_signed & src_a[DATA_W-1];
  assign sign_b    = in_signed & src_b[DATA_W-1];
  assign abs_a     = sign_a ? -src_a : src_a;
  assign abs_b     = sign_b ? -src_b : src_b;
  assign accept    = (state_q == S_IDLE) && start && op_legal && !cancel;

  mdu_datapath #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i ((state_q == S_CALC) && !cancel),
    .div_i  (in_div),
    .opa_i  (abs_a),
    .opb_i  (abs_b),
    .acc_o  (acc),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cancel) state_d = S_IDLE; else if (last) state_d = S_SIGN;
      S_SIGN:  state_d = cancel ? S_IDLE : S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned magnitude result, then the divide-by-zero
  // override and the optional accumulate with the HI/LO values seen at start.
  always_comb begin
    q_signed = ~op_q[0];
    q_div    = (op_q[2:1] == 2'b01);
    prod     = (q_signed && (sign_a_q ^ sign_b_q)) ? -acc : acc;
    quot     = acc[DATA_W-1:0];
    rem      = acc[2*DATA_W-1:DATA_W];
    if (q_signed && (sign_a_q ^ sign_b_q)) quot = -quot;
    if (q_signed && sign_a_q) rem = -rem;
    result = prod;
    if (q_div)
      result = b_zero_q ? {src_a_q, DIV0_LO[DATA_W-1:0]} : {rem, quot};
`ifdef MDU_MADD_EN
    if (op_q[2])
      result = op_q[1] ? ({hi_in_q, lo_in_q} - prod) : ({hi_in_q, lo_in_q} + prod);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      src_a_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_MADD_EN
      hi_in_q  <= '0;
      lo_in_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op;
        sign_a_q <= sign_a;
        sign_b_q <= sign_b;
        b_zero_q <= (src_b == '0);
        src_a_q  <= src_a;
`ifdef MDU_MADD_EN
        hi_in_q  <= hi_in;
        lo_in_q  <= lo_in;
`endif
      end
      if ((state_q == S_SIGN) && !cancel) begin
        hi_q <= result[2*DATA_W-1:DATA_W];
        lo_q <= result[DATA_W-1:0];
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign hilo_write = (state_q == S_WRITE);
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; accumulate tests are built
// only when MDU_MADD_EN is defined.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int WINDOW = 45;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi_in, lo_in;
  logic        busy, hilo_write;
  logic [31:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] rhi, rlo, ev_hi, ev_lo;
  int          lat, wrs, bcyc;
  logic        ev_busy, ev_wr;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .cancel     (cancel),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .busy       (busy),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .hilo_write (hilo_write)
  );

  // Pulses start for one cycle, then watches a fixed window of negedges.
  // restart_at/cancel_at/reset_at inject a second start, a cancel or a reset
  // at that negedge index (1 = first cycle after accept); ev_* are sampled
  // one cycle after the cancel/reset.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, b, hin, lin,
                               input int restart_at, cancel_at, reset_at);
    @(negedge clk);
    op = o; src_a = a; src_b = b; hi_in = hin; lo_in = lin; start = 1'b1;
    lat = 0; wrs = 0; bcyc = 0;
    rhi = hi_out; rlo = lo_out;
    ev_busy = 1'b0; ev_wr = 1'b0; ev_hi = hi_out; ev_lo = lo_out;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (hilo_write) begin
        wrs++;
        if (lat == 0) begin
          lat = k; rhi = hi_out; rlo = lo_out;
        end
      end
      if ((cancel_at > 0 && k == cancel_at + 1) || (reset_at > 0 && k == reset_at + 1)) begin
        ev_busy = busy; ev_wr = hilo_write; ev_hi = hi_out; ev_lo = lo_out;
      end
      start  = (k == restart_at);
      if (k == restart_at) begin
        op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
      end
      cancel = (k == cancel_at);
      rst_n  = (k != reset_at);
    end
    start = 1'b0; cancel = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_MULT;
    src_a = '0; src_b = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (hilo_write !== 1'b0) begin fails++; $display("[TB] FAIL reset_write got %b want 0", hilo_write); end
    tests++; if (hi_out !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi got %h want 0", hi_out); end
    tests++; if (lo_out !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo got %h want 0", lo_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_multu_latency();
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tests++; if (lat !== 34) begin fails++; $display("[TB] FAIL multu_latency got %0d want 34", lat); end
    tests++; if (bcyc !== 34) begin fails++; $display("[TB] FAIL multu_busy_cycles got %0d want 34", bcyc); end
    tests++; if (wrs !== 1) begin fails++; $display("[TB] FAIL multu_writes got %0d want 1", wrs); end
    tests++; if (rhi !== 32'hFFFFFFFE) begin fails++; $display("[TB] FAIL multu_hi got %h want fffffffe", rhi); end
    tests++; if (rlo !== 32'h00000001) begin fails++; $display("[TB] FAIL multu_lo got %h want 00000001", rlo); end
  endtask

  task automatic test_signed();
    applyStimulus(OP_MULT, 32'hFFFFFFF9, 32'd3, 0, 0, 0, 0, 0);
    tests++; if (rhi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mult_neg_hi got %h want ffffffff", rhi); end
    tests++; if (rlo !== 32'hFFFFFFEB) begin fails++; $display("[TB] FAIL mult_neg_lo got %h want ffffffeb", rlo); end
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 0);
    tests++; if (rlo !== 32'hFFFFFFFD) begin fails++; $display("[TB] FAIL div_neg_quot got %h want fffffffd", rlo); end
    tests++; if (rhi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL div_neg_rem got %h want ffffffff", rhi); end
  endtask

  task automatic test_div_special();
    applyStimulus(OP_DIVU, 32'd100, 32'd0, 0, 0, 0, 0, 0);
    tests++; if (rlo !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL div0_lo got %h want ffffffff", rlo); end
    tests++; if (rhi !== 32'd100) begin fails++; $display("[TB] FAIL div0_hi got %h want 00000064", rhi); end
    tests++; if (lat !== 34) begin fails++; $display("[TB] FAIL div0_latency got %0d want 34", lat); end
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tests++; if (rlo !== 32'h80000000) begin fails++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", rlo); end
    tests++; if (rhi !== 32'h0) begin fails++; $display("[TB] FAIL div_ovf_hi got %h want 0", rhi); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 0, 0, 5, 0, 0);
    tests++; if (wrs !== 1) begin fails++; $display("[TB] FAIL b2b_writes got %0d want 1", wrs); end
    tests++; if (rlo !== 32'd42) begin fails++; $display("[TB] FAIL b2b_lo got %h want 0000002a", rlo); end
    tests++; if (hi_out !== 32'h0) begin fails++; $display("[TB] FAIL b2b_hi got %h want 0", hi_out); end
  endtask

  task automatic test_cancel();
    applyStimulus(OP_MULTU, 32'h1234, 32'h10, 0, 0, 0, 11, 0);
    tests++; if (wrs !== 0) begin fails++; $display("[TB] FAIL cancel_writes got %0d want 0", wrs); end
    tests++; if (ev_busy !== 1'b0) begin fails++; $display("[TB] FAIL cancel_busy got %b want 0", ev_busy); end
    tests++; if (lo_out !== 32'd42) begin fails++; $display("[TB] FAIL cancel_lo_hold got %h want 0000002a", lo_out); end
    tests++; if (hi_out !== 32'h0) begin fails++; $display("[TB] FAIL cancel_hi_hold got %h want 0", hi_out); end
  endtask

  task automatic test_midreset();
    applyStimulus(OP_MULTU, 32'h00010000, 32'h00010000, 0, 0, 0, 0, 21);
    tests++; if (ev_busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy got %b want 0", ev_busy); end
    tests++; if (ev_lo !== 32'h0) begin fails++; $display("[TB] FAIL rst_lo got %h want 0", ev_lo); end
    tests++; if (ev_hi !== 32'h0) begin fails++; $display("[TB] FAIL rst_hi got %h want 0", ev_hi); end
    tests++; if (wrs !== 0) begin fails++; $display("[TB] FAIL rst_writes got %0d want 0", wrs); end
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 0, 0, 0, 0, 0);
    tests++; if (rlo !== 32'd15) begin fails++; $display("[TB] FAIL post_rst_lo got %h want 0000000f", rlo); end
    tests++; if (rhi !== 32'h0) begin fails++; $display("[TB] FAIL post_rst_hi got %h want 0", rhi); end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    applyStimulus(OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0, 0, 0);
    tests++; if (rhi !== 32'h1) begin fails++; $display("[TB] FAIL maddu_hi got %h want 00000001", rhi); end
    tests++; if (rlo !== 32'h0) begin fails++; $display("[TB] FAIL maddu_lo got %h want 0", rlo); end
    applyStimulus(OP_MSUB, 32'd1, 32'd1, 32'h0, 32'h0, 0, 0, 0);
    tests++; if (rhi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL msub_hi got %h want ffffffff", rhi); end
    tests++; if (rlo !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL msub_lo got %h want ffffffff", rlo); end
  endtask
`else
  task automatic test_illegal_op();
    applyStimulus(OP_MADD, 32'd2, 32'd2, 0, 0, 0, 0, 0);
    tests++; if (bcyc !== 0) begin fails++; $display("[TB] FAIL illegal_busy_cycles got %0d want 0", bcyc); end
    tests++; if (wrs !== 0) begin fails++; $display("[TB] FAIL illegal_writes got %0d want 0", wrs); end
    tests++; if (lo_out !== 32'd15) begin fails++; $display("[TB] FAIL illegal_lo_hold got %h want 0000000f", lo_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_multu_latency();
    test_signed();
    test_div_special();
    test_back_to_back();
    test_cancel();
    test_midreset();
`ifdef MDU_MADD_EN
    test_madd();
`else
    test_illegal_op();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
